// File: rtl/hand_gesture_pkg.sv
// Shared types for the hand gesture path: gesture codes consumed by the
// downstream decoder and the debounce state encoding.
package hand_gesture_pkg;

    typedef enum logic [3:0] {
        G_NONE   = 4'd0,
        G_UP     = 4'd1,
        G_DOWN   = 4'd2,
        G_LEFT   = 4'd3,
        G_RIGHT  = 4'd4,
        G_FILTER = 4'd5
    } gesture_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACTIVE  = 2'd2
    } dbnc_state_t;

endpackage

// File: rtl/gesture_zone_classifier.sv
// Per-frame raw classification: area gating, centre dead-zone and
// horizontal/vertical dominance, registered on the centroid strobe.
module gesture_zone_classifier
    import hand_gesture_pkg::*;
#(
    parameter int FRAME_WIDTH  = 240,
    parameter int FRAME_HEIGHT = 320,
    parameter int DEAD_X       = 20,
    parameter int DEAD_Y       = 20,
    parameter int MIN_AREA     = 200,
    parameter int BIG_AREA     = 6000,
    parameter int MIRROR_X     = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic [16:0] area_in,
    output logic        raw_valid_out,
    output gesture_t    raw_out
);

    localparam logic signed [11:0] CX = 12'(FRAME_WIDTH / 2);
    localparam logic signed [11:0] CY = 12'(FRAME_HEIGHT / 2);

    logic signed [11:0] dx, dy;
    logic [11:0]        adx, ady;
    gesture_t           code;
    gesture_t           left_code, right_code;

    logic     raw_valid_d, raw_valid_q;
    gesture_t raw_d, raw_q;

    // Selfie cameras see the hand mirrored, so left/right trade places.
    assign left_code  = (MIRROR_X != 0) ? G_RIGHT : G_LEFT;
    assign right_code = (MIRROR_X != 0) ? G_LEFT  : G_RIGHT;

    always_comb begin
        dx   = $signed({1'b0, x_in}) - CX;
        dy   = $signed({2'b00, y_in}) - CY;
        adx  = dx[11] ? 12'(-dx) : 12'(dx);
        ady  = dy[11] ? 12'(-dy) : 12'(dy);
        code = G_NONE;
        if (area_in < 17'(MIN_AREA)) begin
            code = G_NONE;
        end else if (area_in >= 17'(BIG_AREA)) begin
            code = G_FILTER;
        end else if (adx <= 12'(DEAD_X) && ady <= 12'(DEAD_Y)) begin
            code = G_NONE;
        end else if (adx >= ady) begin
            code = dx[11] ? left_code : right_code;
        end else begin
            code = dy[11] ? G_UP : G_DOWN;
        end
    end

    always_comb begin
        raw_valid_d = valid_in;
        raw_d       = valid_in ? code : raw_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            raw_valid_q <= 1'b0;
            raw_q       <= G_NONE;
        end else begin
            raw_valid_q <= raw_valid_d;
            raw_q       <= raw_d;
        end
    end

    assign raw_valid_out = raw_valid_q;
    assign raw_out       = raw_q;

endmodule

// File: rtl/hand_gesture_classifier.sv
// Centroid-to-gesture front end: raw zone classification followed by a
// frame debounce so single-frame glitches never reach the decoder.
module hand_gesture_classifier
    import hand_gesture_pkg::*;
#(
    parameter int FRAME_WIDTH    = 240,
    parameter int FRAME_HEIGHT   = 320,
    parameter int DEAD_X         = 20,
    parameter int DEAD_Y         = 20,
    parameter int MIN_AREA       = 200,
    parameter int BIG_AREA       = 6000,
    parameter int CONFIRM_FRAMES = 3,
    parameter int MIRROR_X       = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        centroid_valid_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic [16:0] area_in,
    output logic        new_data_out,
    output logic [3:0]  data_out
);

    logic     raw_valid;
    gesture_t raw;

    gesture_zone_classifier #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .FRAME_HEIGHT(FRAME_HEIGHT),
        .DEAD_X      (DEAD_X),
        .DEAD_Y      (DEAD_Y),
        .MIN_AREA    (MIN_AREA),
        .BIG_AREA    (BIG_AREA),
        .MIRROR_X    (MIRROR_X)
    ) u_zone (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .valid_in     (centroid_valid_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .area_in      (area_in),
        .raw_valid_out(raw_valid),
        .raw_out      (raw)
    );

    dbnc_state_t state_d, state_q;
    gesture_t    cand_d, cand_q;
    logic [3:0]  cnt_d, cnt_q;
    logic        new_data_d, new_data_q;
    gesture_t    data_d, data_q;
    logic [4:0]  cnt_inc;
    logic [3:0]  cnt_sat;

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + 5'd1;
        cnt_sat = (cnt_inc >= 5'(CONFIRM_FRAMES)) ? 4'(CONFIRM_FRAMES) : cnt_inc[3:0];
    end

    // Only accepted frames advance the debounce; idle cycles hold everything.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        new_data_d = 1'b0;
        data_d     = G_NONE;
        if (raw_valid) begin
            new_data_d = 1'b1;
            if (raw == G_NONE) begin
                state_d = ST_NONE;
                cand_d  = G_NONE;
                cnt_d   = 4'd0;
            end else if (raw != cand_q) begin
                cand_d = raw;
                cnt_d  = 4'd1;
                if (CONFIRM_FRAMES == 1) begin
                    state_d = ST_ACTIVE;
                    data_d  = raw;
                end else begin
                    state_d = ST_PENDING;
                end
            end else begin
                cnt_d = cnt_sat;
                if (cnt_sat == 4'(CONFIRM_FRAMES)) begin
                    state_d = ST_ACTIVE;
                    data_d  = cand_q;
                end else begin
                    state_d = ST_PENDING;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_NONE;
            cand_q     <= G_NONE;
            cnt_q      <= 4'd0;
            new_data_q <= 1'b0;
            data_q     <= G_NONE;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            new_data_q <= new_data_d;
            data_q     <= data_d;
        end
    end

    assign new_data_out = new_data_q;
    assign data_out     = data_q;

endmodule
